// File: rtl/xor_stream_encryptor.sv
// Multibyte-key XOR stream encryptor: key table loaded from sysbus, plaintext
// words XORed with the key words in rotation onto a registered output stream.
module xor_stream_encryptor #(
    parameter int unsigned WORD_W    = 10,
    parameter int unsigned KEY_MAX   = 4,
    parameter int unsigned KEY_IDX_W = 2
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 key_load,
    input  logic                 key_clear,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 STAT_bus,
    inout  wire  [WORD_W-1:0]    sysbus,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [KEY_IDX_W:0]   key_len
);

    localparam int unsigned CNT_W = KEY_IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WORD_W-1:0]     key_tab [KEY_MAX];
    logic [CNT_W-1:0]      key_cnt;
    logic [KEY_IDX_W-1:0]  key_idx;
    logic [WORD_W-1:0]     word_cnt;

    logic                  accept;
    logic                  start_run;
    logic                  key_wr;
    logic                  key_last;

    // State register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input handshake and control strobes
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        start_run  = 1'b0;
        key_wr     = 1'b0;
        case (state)
            IDLE: begin
                key_wr = key_load && !key_clear && (key_cnt < CNT_W'(KEY_MAX));
                // start sees the key count from before any same-cycle load
                if (start && (key_cnt != '0)) begin
                    start_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (stop) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        accept = in_valid && in_ready;
    end

    assign key_last = (CNT_W'(key_idx) == (key_cnt - CNT_W'(1)));

    // Key table and key count
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < KEY_MAX; i++) begin
                key_tab[i] <= '0;
            end
            key_cnt <= '0;
        end else if (state == IDLE) begin
            if (key_clear) begin
                key_cnt <= '0;
            end else if (key_wr) begin
                key_tab[key_cnt[KEY_IDX_W-1:0]] <= sysbus;
                key_cnt                         <= key_cnt + CNT_W'(1);
            end
        end
    end

    // Encryption datapath, key rotation and word counter
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            key_idx   <= '0;
            word_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (start_run) begin
                key_idx  <= '0;
                word_cnt <= '0;
            end
            if (accept) begin
                out_data  <= in_data ^ key_tab[key_idx];
                out_valid <= 1'b1;
                key_idx   <= key_last ? '0 : key_idx + KEY_IDX_W'(1);
                word_cnt  <= word_cnt + WORD_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign key_len = key_cnt;
    assign sysbus  = STAT_bus ? word_cnt : {WORD_W{1'bz}};

endmodule
